// File: rtl/demux_rr_dispatcher.sv
// Round-robin dispatcher feeding a 1-to-4 demux: holds one beat with its
// committed destination channel and a delivered-beat counter.
module demux_rr_dispatcher #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ch_en,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [CNT_W-1:0] beat_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] data_reg;
    logic [1:0]       sel_reg;
    logic [1:0]       ptr_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       dest_next;
    logic             accept;
    logic             deliver;

    assign deliver  = (state_reg == FULL) && out_ready[sel_reg];
    assign in_ready = (ch_en != 4'b0000) && ((state_reg == EMPTY) || deliver);
    assign accept   = in_valid && in_ready;

    // Descending scan so the enabled channel closest to ptr wins.
    always_comb begin
        logic [1:0] idx;
        dest_next = ptr_reg;
        idx       = ptr_reg;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_reg + 2'(k);
            if (ch_en[idx]) begin
                dest_next = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            data_reg  <= '0;
            sel_reg   <= 2'd0;
            ptr_reg   <= 2'd0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        state_reg <= FULL;
                        data_reg  <= in_data;
                        sel_reg   <= dest_next;
                    end
                end
                FULL: begin
                    if (accept) begin
                        data_reg <= in_data;
                        sel_reg  <= dest_next;
                    end else if (deliver) begin
                        state_reg <= EMPTY;
                    end
                end
                default: state_reg <= EMPTY;
            endcase
            if (accept) begin
                ptr_reg <= dest_next + 2'd1;
            end
            if (deliver) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Valid is a pure decode of state and committed select, so reset clears it at once.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_valid
            assign out_valid[gi] = (state_reg == FULL) && (sel_reg == 2'(gi));
        end
    endgenerate

    assign out_data = data_reg;
    assign out_sel  = sel_reg;
    assign beat_cnt = cnt_reg;

endmodule
